song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
Auto-mode playback controller for the electric piano. It sequences one of 16 songs from the shared note ROM and times each note's duration and inter-note gap. It also muxes the auto-play note stream with the live manual-key note onto the single tone-generator/beeper input. It sits between Mode_Controller / Array_KeyBoard decode and the beeper tone divider.

Parameters:
CLK_HZ, 12000000, system clock frequency
BEAT_MS, 125, duration of one beat in ms
TICKS_PER_BEAT, CLK_HZ/1000*BEAT_MS, clocks per beat (overridable for simulation)
GAP_TICKS, TICKS_PER_BEAT/8, silent clocks between notes; 0 disables the gap
IDX_W, 6, note index width (64 note slots per song)

Ports:
clk  in  1  system clock, 12 MHz
rst_n  in  1  asynchronous active-low reset
mode  in  1  0=manual, 1=auto (from Mode_Controller current_mode)
manual_note  in  5  note code of the held manual key; 0=silence
song_start  in  1  one-cycle pulse, start song song_sel
song_sel  in  4  song number 0..15, sampled with song_start
song_stop  in  1  one-cycle pulse, abort playback
rom_addr  out  4+IDX_W  {song, index}, registered
rom_data  in  8  [7:3]=note code, [2:0]=len; valid one cycle after rom_addr
note_out  out  5  note code to tone generator; 0=silence
playing  out  1  high while a song is active
cur_song  out  4  song currently or last played
song_done  out  1  one-cycle pulse on natural end of song

Behaviour:
- Reset: all outputs 0. State IDLE, index 0.
- States: IDLE, FETCH, WAIT, PLAY, GAP, DONE.
- IDLE: on song_start with mode=1:
  - latch cur_song<=song_sel, index<=0;
  - go to FETCH on the next cycle.
  - song_start with mode=0 is ignored.
- FETCH (1 cycle): rom_addr<={cur_song,index}; go to WAIT.
- WAIT (1 cycle): sample rom_data at the end of the cycle.
  - rom_data==8'h00 is the end marker: go to DONE.
  - Otherwise latch note/len, load duration=(len+1)*TICKS_PER_BEAT, go to PLAY.
- PLAY: note_out=latched note (note 0 = rest). The down-counter reaches 0 after exactly (len+1)*TICKS_PER_BEAT cycles in PLAY.
  - Then go to GAP, or to FETCH if GAP_TICKS=0.
  - Increment index on leaving PLAY.
- GAP: note_out=0 for exactly GAP_TICKS cycles, then FETCH.
- Index wrap: if index was 2^IDX_W-1 when leaving PLAY, go to DONE instead of fetching (no wrap to 0).
- DONE (1 cycle): song_done=1, playing=0 next cycle, return to IDLE.
- playing=1 in FETCH, WAIT, PLAY and GAP; 0 in IDLE and DONE.
- Latency: song_start sampled at edge k → FETCH at k+1, WAIT at k+2, PLAY with note_out valid at k+3.
- song_start while playing: restart immediately.
  - Latch the new song_sel, index=0, go to FETCH next cycle.
  - No song_done for the abandoned song.
- song_stop in any non-IDLE state: go to IDLE next cycle, note_out=0, no song_done.
  - song_stop and song_start in the same cycle: stop wins.
- Auto-mode abort: mode falling to 0 while playing acts as song_stop.
- Output mux: mode=0 → note_out registered from manual_note (1-cycle latency) in every state. mode=1 → note_out from the sequencer; manual_note is ignored.
- Reset asserted mid-song: asynchronously return to reset values; no pulses generated.
- Counter width: clog2(8*TICKS_PER_BEAT+1). No overflow is possible.

Decomposition:
- Shared package piano_pkg:
  - note code constants (REST=0, DO..high notes);
  - END_MARKER=8'h00;
  - sequencer state enum;
  - NUM_SONGS=16;
  - ROM field positions.
- One sub-module, note_timer: loadable down-counter with load, count and expire outputs. It is reused for both PLAY and GAP durations.

Test Plan:
All tests use TICKS_PER_BEAT=4, GAP_TICKS=2.
- Reset/manual: rst_n low, then mode=0, manual_note=5 → note_out=0 during reset, 5 one cycle after release; playing=0.
- Basic song: ROM song 3 = {0x2A, 0x31, 0x00}; pulse song_start, song_sel=3 at edge k.
  - rom_addr=0x0C0 at k+1.
  - note_out=5 for cycles k+3..k+14 (len 2 → 12 cycles), then 0 for 2 cycles.
  - Next note, 6 for 8 cycles, then 2-cycle gap.
  - Then the end marker: song_done for 1 cycle; playing falls.
- Restart: song_start with song_sel=7 during PLAY of song 3 → FETCH next cycle with rom_addr=0x1C0; no song_done for song 3.
- Stop priority: song_stop and song_start in the same cycle mid-song → IDLE, note_out=0 next cycle, no song_done.
- Mode abort: mode 1→0 in PLAY with manual_note=9 → playing=0 and note_out=9 one cycle later.
- Index wrap: song 15 with 64 non-zero entries → after the 64th note plus gap, song_done pulses; rom_addr never returns to 0x3C0.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the electric-piano playback path.
//   - note code constants (REST plus two octaves of scale notes)
//   - note-ROM entry layout: [7:3] note code, [2:0] length in beats minus one
//   - song sequencer state encoding
package piano_pkg;

  localparam int NOTE_W    = 5;
  localparam int LEN_W     = 3;
  localparam int SONG_W    = 4;
  localparam int NUM_SONGS = 16;

  // Note-ROM field positions
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 3;
  localparam int LEN_MSB  = 2;
  localparam int LEN_LSB  = 0;

  localparam logic [7:0] END_MARKER = 8'h00;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_DO   = 5'd1;
  localparam logic [NOTE_W-1:0] NOTE_RE   = 5'd2;
  localparam logic [NOTE_W-1:0] NOTE_MI   = 5'd3;
  localparam logic [NOTE_W-1:0] NOTE_FA   = 5'd4;
  localparam logic [NOTE_W-1:0] NOTE_SO   = 5'd5;
  localparam logic [NOTE_W-1:0] NOTE_LA   = 5'd6;
  localparam logic [NOTE_W-1:0] NOTE_SI   = 5'd7;
  localparam logic [NOTE_W-1:0] NOTE_DO_H = 5'd8;
  localparam logic [NOTE_W-1:0] NOTE_RE_H = 5'd9;
  localparam logic [NOTE_W-1:0] NOTE_MI_H = 5'd10;
  localparam logic [NOTE_W-1:0] NOTE_FA_H = 5'd11;
  localparam logic [NOTE_W-1:0] NOTE_SO_H = 5'd12;
  localparam logic [NOTE_W-1:0] NOTE_LA_H = 5'd13;
  localparam logic [NOTE_W-1:0] NOTE_SI_H = 5'd14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_GAP,
    S_DONE
  } seq_state_e;

  function automatic logic [NOTE_W-1:0] rom_note(input logic [7:0] entry);
    return entry[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [LEN_W-1:0] rom_len(input logic [7:0] entry);
    return entry[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter used to time both note durations and inter-note gaps.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (takes priority over counting)
//   load_val_i  : number of counting cycles to time
//   count_i     : decrement enable
//   expire_o    : high during the last counting cycle of a loaded interval
module note_timer
  import piano_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             count_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Expiring on the value 1 lets a load of N produce exactly N counting cycles,
  // with the counter landing on 0 as the owner moves on.
  assign expire_o = count_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// Auto-mode playback controller: walks one of 16 songs in the note ROM,
// times each note and the silent gap after it, and muxes the result with the
// live manual key onto the tone generator input.
//   mode        : 0 = manual (note_out follows manual_note), 1 = auto
//   manual_note : note code of the held key, 0 = silence
//   song_start  : pulse, start (or restart) song song_sel
//   song_stop   : pulse, abort playback; wins over song_start
//   rom_addr    : {song, index} into the shared note ROM, registered
//   rom_data    : ROM entry, valid one cycle after rom_addr
//   note_out    : registered note code to the tone generator
//   playing     : song active (FETCH/WAIT/PLAY/GAP)
//   cur_song    : song currently or last played
//   song_done   : one-cycle pulse on natural end of song
module song_sequencer
  import piano_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int BEAT_MS        = 125,
  parameter int TICKS_PER_BEAT = CLK_HZ / 1000 * BEAT_MS,
  parameter int GAP_TICKS      = TICKS_PER_BEAT / 8,
  parameter int IDX_W          = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [NOTE_W-1:0]       manual_note,
  input  logic                    song_start,
  input  logic [SONG_W-1:0]       song_sel,
  input  logic                    song_stop,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [7:0]              rom_data,
  output logic [NOTE_W-1:0]       note_out,
  output logic                    playing,
  output logic [SONG_W-1:0]       cur_song,
  output logic                    song_done
);

  localparam int CNT_W = $clog2(8 * TICKS_PER_BEAT + 1);

  seq_state_e              state_q, state_d;
  logic [SONG_W-1:0]       cur_song_q, cur_song_d;
  // One extra bit: it sets when the last slot has been played, which ends
  // the song instead of wrapping back to slot 0.
  logic [IDX_W:0]          index_q, index_d;
  logic [NOTE_W-1:0]       note_q, note_d;
  logic [SONG_W+IDX_W-1:0] rom_addr_q;
  logic [NOTE_W-1:0]       note_out_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_count;
  logic             tmr_expire;
  logic             abort;

  note_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .count_i    (tmr_count),
    .expire_o   (tmr_expire)
  );

  // Leaving auto mode while a song is active behaves exactly like song_stop.
  assign abort = song_stop || (!mode && (state_q != S_IDLE));

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cur_song_d = cur_song_q;
    index_d    = index_q;
    note_d     = note_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_count  = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
    end else if (song_start && mode) begin
      state_d    = S_FETCH;
      cur_song_d = song_sel;
      index_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (rom_data == END_MARKER) begin
            state_d = S_DONE;
          end else begin
            note_d   = rom_note(rom_data);
            tmr_load = 1'b1;
            tmr_val  = CNT_W'((int'(rom_len(rom_data)) + 1) * TICKS_PER_BEAT);
            state_d  = S_PLAY;
          end
        end
        S_PLAY: begin
          tmr_count = 1'b1;
          if (tmr_expire) begin
            index_d = index_q + (IDX_W+1)'(1);
            if (GAP_TICKS == 0) begin
              state_d = index_d[IDX_W] ? S_DONE : S_FETCH;
            end else begin
              tmr_load = 1'b1;
              tmr_val  = CNT_W'(GAP_TICKS);
              state_d  = S_GAP;
            end
          end
        end
        S_GAP: begin
          tmr_count = 1'b1;
          if (tmr_expire) begin
            state_d = index_q[IDX_W] ? S_DONE : S_FETCH;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_song_q <= '0;
      index_q    <= '0;
      note_q     <= NOTE_REST;
      rom_addr_q <= '0;
      note_out_q <= NOTE_REST;
    end else begin
      state_q    <= state_d;
      cur_song_q <= cur_song_d;
      index_q    <= index_d;
      note_q     <= note_d;
      if (state_q == S_FETCH) begin
        rom_addr_q <= {cur_song_q, index_q[IDX_W-1:0]};
      end
      // The sequencer note is gated off as soon as a stop or restart is seen
      // so the tone generator never hears a stale note for an extra cycle.
      if (!mode) begin
        note_out_q <= manual_note;
      end else if ((state_q == S_PLAY) && !song_stop && !song_start) begin
        note_out_q <= note_q;
      end else begin
        note_out_q <= NOTE_REST;
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign note_out  = note_out_q;
  assign cur_song  = cur_song_q;
  assign playing   = (state_q == S_FETCH) || (state_q == S_WAIT) ||
                     (state_q == S_PLAY)  || (state_q == S_GAP);
  assign song_done = (state_q == S_DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer (TICKS_PER_BEAT=4, GAP_TICKS=2).
// Each scenario pushes the per-cycle expected outputs derived from the ROM
// contents, drives its stimulus, and pops one entry per clock.
module tb_song_sequencer;

  localparam int T = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [4:0] manual_note;
  logic       song_start;
  logic [3:0] song_sel;
  logic       song_stop;
  logic [9:0] rom_addr;
  logic [7:0] rom_data;
  logic [4:0] note_out;
  logic       playing;
  logic [3:0] cur_song;
  logic       song_done;

  logic [7:0] rom [0:1023];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  song_sequencer #(
    .TICKS_PER_BEAT (T),
    .GAP_TICKS      (G),
    .IDX_W          (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .manual_note (manual_note),
    .song_start  (song_start),
    .song_sel    (song_sel),
    .song_stop   (song_stop),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .note_out    (note_out),
    .playing     (playing),
    .cur_song    (cur_song),
    .song_done   (song_done)
  );

  typedef struct packed {
    logic [4:0] note;
    logic       playing;
    logic       done;
    logic       chk_addr;
    logic [9:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] n, input logic p, input logic d,
                      input logic c, input logic [9:0] a);
    exp_t e;
    e.note     = n;
    e.playing  = p;
    e.done     = d;
    e.chk_addr = c;
    e.addr     = a;
    exp_q.push_back(e);
  endtask

  // Expected trace of a full natural playback, starting with the FETCH cycle
  // that follows the song_start edge.
  task automatic build_song(input logic [3:0] song);
    logic [9:0] addr;
    logic [7:0] d;
    int         dur;
    addr = 10'd0;
    for (int idx = 0; idx < 64; idx++) begin
      push(5'd0, 1'b1, 1'b0, (idx != 0), addr);           // FETCH
      addr = {song, 6'(idx)};
      d    = rom[addr];
      push(5'd0, 1'b1, 1'b0, 1'b1, addr);                 // WAIT
      if (d == 8'h00) begin
        push(5'd0, 1'b0, 1'b1, 1'b1, addr);               // DONE
        push(5'd0, 1'b0, 1'b0, 1'b1, addr);               // IDLE
        return;
      end
      dur = (int'(d[2:0]) + 1) * T;
      push(5'd0, 1'b1, 1'b0, 1'b1, addr);                 // first PLAY cycle
      for (int c = 1; c < dur; c++) push(d[7:3], 1'b1, 1'b0, 1'b1, addr);
      push(d[7:3], 1'b1, 1'b0, 1'b1, addr);               // first GAP cycle
      for (int c = 1; c < G; c++) push(5'd0, 1'b1, 1'b0, 1'b1, addr);
    end
    push(5'd0, 1'b0, 1'b1, 1'b1, addr);                   // DONE after slot 63
    push(5'd0, 1'b0, 1'b0, 1'b1, addr);
  endtask

  task automatic trim(input int n);
    while (exp_q.size() > n) void'(exp_q.pop_back());
  endtask

  task automatic step();
    exp_t e;
    cycle();
    e = exp_q.pop_front();
    check("note_out",  32'(note_out),  32'(e.note));
    check("playing",   32'(playing),   32'(e.playing));
    check("song_done", 32'(song_done), 32'(e.done));
    if (e.chk_addr) check("rom_addr", 32'(rom_addr), 32'(e.addr));
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask

  task automatic start_pulse(input logic [3:0] sel);
    song_sel   = sel;
    song_start = 1'b1;
    step();
    song_start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    rom[192] = 8'h2A;                 // song 3: note 5, len 2
    rom[193] = 8'h31;                 //         note 6, len 1
    rom[448] = 8'h19;                 // song 7: note 3, len 1
    for (int i = 0; i < 64; i++) rom[960 + i] = {5'((i % 31) + 1), 3'(i % 2)};

    rst_n       = 1'b0;
    mode        = 1'b0;
    manual_note = 5'd5;
    song_start  = 1'b0;
    song_sel    = 4'd0;
    song_stop   = 1'b0;

    // Reset and manual pass-through
    repeat (3) cycle();
    check("rst_note",     32'(note_out),  32'd0);
    check("rst_playing",  32'(playing),   32'd0);
    check("rst_done",     32'(song_done), 32'd0);
    check("rst_rom_addr", 32'(rom_addr),  32'd0);
    check("rst_cur_song", 32'(cur_song),  32'd0);
    rst_n = 1'b1;
    cycle();
    check("manual_note",    32'(note_out), 32'd5);
    check("manual_playing", 32'(playing),  32'd0);

    // song_start in manual mode is ignored
    manual_note = 5'd0;
    repeat (3) push(5'd0, 1'b0, 1'b0, 1'b1, 10'd0);
    start_pulse(4'd3);
    drain();
    check("ign_cur_song", 32'(cur_song), 32'd0);

    // Basic song 3 through its end marker
    mode = 1'b1;
    build_song(4'd3);
    start_pulse(4'd3);
    drain();
    check("basic_cur_song", 32'(cur_song), 32'd3);

    // Restart to song 7 during PLAY of song 3
    build_song(4'd3);
    trim(5);
    start_pulse(4'd3);
    drain();
    build_song(4'd7);
    start_pulse(4'd7);
    drain();
    check("restart_cur_song", 32'(cur_song), 32'd7);

    // Stop and start in the same cycle: stop wins
    build_song(4'd3);
    trim(5);
    start_pulse(4'd3);
    drain();
    repeat (3) push(5'd0, 1'b0, 1'b0, 1'b1, 10'h0C0);
    song_sel   = 4'd7;
    song_stop  = 1'b1;
    song_start = 1'b1;
    step();
    song_stop  = 1'b0;
    song_start = 1'b0;
    drain();
    check("stop_cur_song", 32'(cur_song), 32'd3);

    // Mode falling during PLAY aborts and hands over to the manual key
    build_song(4'd3);
    trim(5);
    start_pulse(4'd3);
    drain();
    repeat (2) push(5'd9, 1'b0, 1'b0, 1'b1, 10'h0C0);
    mode        = 1'b0;
    manual_note = 5'd9;
    drain();
    manual_note = 5'd0;
    mode        = 1'b1;

    // Song 15 fills all 64 slots: it must end without wrapping to slot 0
    build_song(4'd15);
    start_pulse(4'd15);
    drain();
    check("wrap_cur_song", 32'(cur_song), 32'd15);

    // Asynchronous reset in the middle of a note
    build_song(4'd3);
    trim(8);
    start_pulse(4'd3);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_note",     32'(note_out),  32'd0);
    check("arst_playing",  32'(playing),   32'd0);
    check("arst_done",     32'(song_done), 32'd0);
    check("arst_rom_addr", 32'(rom_addr),  32'd0);
    check("arst_cur_song", 32'(cur_song),  32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();
    check("post_arst_playing", 32'(playing), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
